// File: rtl/line_fetcher_if.sv
// VRAM read port and renderer handshake seen by the line fetcher.
// The fetcher is the master: it drives the VRAM address and the render item,
// and receives read data plus the renderer's busy/last_pixel status.
interface line_fetcher_if;
  logic [12:0] vram_addr;
  logic [15:0] vram_rddata;
  logic [7:0]  render_idx;
  logic [31:0] render_data;
  logic        render_start;
  logic        is_sprite;
  logic        hflip;
  logic        palette;
  logic        render_priority;
  logic        render_busy;
  logic        render_last_pixel;

  modport master (
    output vram_addr, render_idx, render_data, render_start,
           is_sprite, hflip, palette, render_priority,
    input  vram_rddata, render_busy, render_last_pixel
  );

  modport slave (
    input  vram_addr, render_idx, render_data, render_start,
           is_sprite, hflip, palette, render_priority,
    output vram_rddata, render_busy, render_last_pixel
  );
endinterface

// File: rtl/line_fetcher.sv
// Per-scanline fetch sequencer: 32 background tiles then up to 8 sprites,
// planar-to-chunky conversion, one 8-pixel item staged for the renderer.
//
// state   | meaning
// IDLE    | waiting for line_start
// NAME    | name-table address on the bus (background only)
// PAT0    | name entry arriving; pattern word 0 (planes 1:0) addressed
// PAT1    | planes 1:0 arriving; pattern word 1 (planes 3:2) addressed
// CAPT    | planes 3:2 arriving; item written to staging if it is free
// HOLD    | item held until staging frees up
// DRAIN   | last item staged; wait for it to issue and the renderer to finish
module line_fetcher (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [7:0]    bg_row,
  input  logic [7:0]    hscroll,
  input  logic [2:0]    nt_base,
  input  logic          spr_pattern_base,
  input  logic [3:0]    spr_count,
  output logic [2:0]    spr_sel,
  input  logic [7:0]    spr_x,
  input  logic [7:0]    spr_pattern,
  input  logic [2:0]    spr_row,
  output logic          busy,
  output logic          done,
  line_fetcher_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_NAME, S_PAT0, S_PAT1, S_CAPT, S_HOLD, S_DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  col;
  logic [2:0]  spr_idx;
  logic        in_spr;
  logic [3:0]  spr_total;
  logic        ent_hflip, ent_pal, ent_pri;
  logic [7:0]  cur_x;
  logic [15:0] plane01, plane23;
  logic [12:0] addr_q;
  logic        stage_valid;
  logic [7:0]  stage_idx;
  logic [31:0] stage_data;
  logic        stage_spr, stage_hflip, stage_pal, stage_pri;
  logic        stage_free, load_stage, last_item;
  logic [15:0] p23;
  logic [31:0] chunky;
  logic [2:0]  fine_r;

  assign bus.render_start    = stage_valid & (~bus.render_busy | bus.render_last_pixel);
  assign bus.render_idx      = stage_idx;
  assign bus.render_data     = stage_data;
  assign bus.is_sprite       = stage_spr;
  assign bus.hflip           = stage_hflip;
  assign bus.palette         = stage_pal;
  assign bus.render_priority = stage_pri;
  assign busy    = (state != S_IDLE);
  assign spr_sel = spr_idx;

  // Staging can take a new item when empty or when its item issues this cycle.
  assign stage_free = ~stage_valid | bus.render_start;
  assign last_item  = in_spr ? (({1'b0, spr_idx} + 4'd1) == spr_total)
                             : ((col == 5'd31) && (spr_total == 4'd0));

  // Next state, VRAM address and done; the address holds its last value by default.
  always_comb begin
    state_nx      = state;
    bus.vram_addr = addr_q;
    load_stage    = 1'b0;
    done          = 1'b0;
    fine_r        = bg_row[2:0] ^ {3{bus.vram_rddata[10]}};
    case (state)
      S_IDLE: state_nx = S_IDLE;
      S_NAME: begin
        bus.vram_addr = {nt_base, bg_row[7:3], col};
        state_nx      = S_PAT0;
      end
      S_PAT0: begin
        if (in_spr) bus.vram_addr = {spr_pattern_base, spr_pattern, spr_row, 1'b0};
        else        bus.vram_addr = {bus.vram_rddata[8:0], fine_r, 1'b0};
        state_nx = S_PAT1;
      end
      // Word 1 sits right after word 0, which addr_q still holds.
      S_PAT1: begin
        bus.vram_addr = {addr_q[12:1], 1'b1};
        state_nx      = S_CAPT;
      end
      S_CAPT, S_HOLD: begin
        if (stage_free) begin
          load_stage = 1'b1;
          if (last_item)                  state_nx = S_DRAIN;
          else if (in_spr || col == 5'd31) state_nx = S_PAT0;
          else                            state_nx = S_NAME;
        end else begin
          state_nx = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (!stage_valid && !bus.render_busy) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (line_start) begin
      state_nx   = S_NAME;
      load_stage = 1'b0;
      done       = 1'b0;
    end
  end

  // Planar to chunky: pixel x (leftmost first) lands in the top nibble downwards.
  always_comb begin
    p23    = (state == S_CAPT) ? bus.vram_rddata : plane23;
    chunky = '0;
    for (int x = 0; x < 8; x++) begin
      chunky[31-4*x -: 4] = {p23[15-x], p23[7-x], plane01[15-x], plane01[7-x]};
    end
  end

  // State, fetch latches, item counters and the staging register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      col         <= '0;
      spr_idx     <= '0;
      in_spr      <= 1'b0;
      spr_total   <= '0;
      ent_hflip   <= 1'b0;
      ent_pal     <= 1'b0;
      ent_pri     <= 1'b0;
      cur_x       <= '0;
      plane01     <= '0;
      plane23     <= '0;
      stage_valid <= 1'b0;
      stage_idx   <= '0;
      stage_data  <= '0;
      stage_spr   <= 1'b0;
      stage_hflip <= 1'b0;
      stage_pal   <= 1'b0;
      stage_pri   <= 1'b0;
    end else begin
      state  <= state_nx;
      addr_q <= bus.vram_addr;
      if (state == S_PAT0) begin
        ent_hflip <= bus.vram_rddata[9];
        ent_pal   <= bus.vram_rddata[11];
        ent_pri   <= bus.vram_rddata[12];
        cur_x     <= spr_x;
      end
      if (state == S_PAT1) plane01 <= bus.vram_rddata;
      if (state == S_CAPT) plane23 <= bus.vram_rddata;

      if (line_start) begin
        stage_valid <= 1'b0;
        col         <= '0;
        spr_idx     <= '0;
        in_spr      <= 1'b0;
        spr_total   <= (spr_count > 4'd8) ? 4'd8 : spr_count;
      end else if (load_stage) begin
        stage_valid <= 1'b1;
        stage_data  <= chunky;
        stage_spr   <= in_spr;
        stage_idx   <= in_spr ? cur_x : ({col, 3'b000} + hscroll);
        stage_hflip <= in_spr ? 1'b0 : ent_hflip;
        stage_pal   <= in_spr ? 1'b1 : ent_pal;
        stage_pri   <= in_spr ? 1'b0 : ent_pri;
        if (in_spr)             spr_idx <= spr_idx + 3'd1;
        else if (col == 5'd31)  in_spr  <= 1'b1;
        else                    col     <= col + 5'd1;
      end else if (bus.render_start) begin
        stage_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_fetcher.sv
// Self-checking bench for line_fetcher: VRAM and renderer models, a
// per-line reference of every item computed from the tile/sprite rules,
// directed scenarios plus randomized lines with an occasional restart.
module tb_line_fetcher;
  logic       clk = 1'b0;
  logic       reset, line_start;
  logic [7:0] bg_row, hscroll;
  logic [2:0] nt_base;
  logic       spr_pattern_base;
  logic [3:0] spr_count;
  logic [2:0] spr_sel;
  logic [7:0] spr_x, spr_pattern;
  logic [2:0] spr_row;
  logic       busy, done;

  line_fetcher_if bus ();

  line_fetcher dut (
    .clk(clk), .reset(reset), .line_start(line_start),
    .bg_row(bg_row), .hscroll(hscroll), .nt_base(nt_base),
    .spr_pattern_base(spr_pattern_base), .spr_count(spr_count),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_pattern(spr_pattern),
    .spr_row(spr_row), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [8192];
  logic [7:0]  sx_t [8];
  logic [7:0]  sp_t [8];
  logic [2:0]  sr_t [8];
  logic [3:0]  rcnt;

  assign spr_x       = sx_t[spr_sel];
  assign spr_pattern = sp_t[spr_sel];
  assign spr_row     = sr_t[spr_sel];

  // VRAM: data for the address of the previous cycle.
  always_ff @(posedge clk) bus.vram_rddata <= mem[bus.vram_addr];

  // Renderer: eight pixel cycles per item, last_pixel on the eighth.
  always_ff @(posedge clk) begin
    if (reset)                 rcnt <= '0;
    else if (bus.render_start) rcnt <= 4'd8;
    else if (rcnt != 4'd0)     rcnt <= rcnt - 4'd1;
  end
  assign bus.render_busy       = (rcnt != 4'd0);
  assign bus.render_last_pixel = (rcnt == 4'd1);

  int checks = 0, failures = 0;
  int cyc = 0, line_l = -1000, done_cyc = -1000, k_iss = 0, exp_n = 0, done_cnt = 0;
  bit line_act = 0, done_seen = 0, pair_seen = 0;
  logic [12:0] pair_a, pair_b, prev_addr;
  logic [12:0] addr_t [4];
  logic [7:0]  exp_idx [40];
  logic [31:0] exp_data [40];
  logic        exp_spr [40], exp_hf [40], exp_pal [40], exp_pri [40];
  int          obs_cyc [40];
  logic [7:0]  obs_idx [40];
  logic [31:0] obs_data [40];
  logic        obs_spr [40], obs_pri [40], obs_hf [40], obs_pal [40];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%08h want=0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] to_chunky(input int w0, input int w1);
    logic [31:0] d = 0;
    int p0 = w0 % 256, p1 = (w0 / 256) % 256, p2 = w1 % 256, p3 = (w1 / 256) % 256;
    for (int x = 0; x < 8; x++) begin
      int b = 7 - x;
      int nib = ((p3 >> b) & 1) * 8 + ((p2 >> b) & 1) * 4 + ((p1 >> b) & 1) * 2 + ((p0 >> b) & 1);
      d = d | (32'(nib) << (28 - 4 * x));
    end
    return d;
  endfunction

  // Reference: every item of the line, from the current inputs and VRAM.
  task automatic build_expect();
    int nspr = (spr_count > 8) ? 8 : int'(spr_count);
    int ent, r, pa, w0, w1;
    exp_n = 32 + nspr;
    for (int k = 0; k < exp_n; k++) begin
      if (k < 32) begin
        ent = int'(mem[int'(nt_base) * 1024 + (int'(bg_row) / 8) * 32 + k]);
        r   = int'(bg_row) % 8;
        if ((ent / 1024) % 2 == 1) r = 7 - r;
        pa  = (ent % 512) * 16 + r * 2;
        exp_idx[k] = 8'((8 * k + int'(hscroll)) % 256);
        exp_spr[k] = 1'b0;
        exp_hf[k]  = 1'((ent / 512) % 2);
        exp_pal[k] = 1'((ent / 2048) % 2);
        exp_pri[k] = 1'((ent / 4096) % 2);
      end else begin
        pa = int'(spr_pattern_base) * 4096 + int'(sp_t[k-32]) * 16 + int'(sr_t[k-32]) * 2;
        exp_idx[k] = sx_t[k-32];
        exp_spr[k] = 1'b1;
        exp_hf[k]  = 1'b0;
        exp_pal[k] = 1'b1;
        exp_pri[k] = 1'b0;
      end
      w0 = int'(mem[pa]);
      w1 = int'(mem[pa + 1]);
      exp_data[k] = to_chunky(w0, w1);
    end
  endtask

  task automatic monitor();
    if (line_act && cyc >= line_l + 1 && cyc <= line_l + 3) addr_t[cyc - line_l] = bus.vram_addr;
    if (line_act && cyc == line_l + 1) check_val("busy_rise", 32'(busy), 32'd1);
    if (line_act && prev_addr == pair_a && bus.vram_addr == pair_b) pair_seen = 1;
    prev_addr = bus.vram_addr;
    if (bus.render_start === 1'b1) begin
      if (!line_act || k_iss >= exp_n) begin
        check_val("stray_start", 32'(bus.render_start), 32'd0);
      end else begin
        obs_cyc[k_iss]  = cyc;
        obs_idx[k_iss]  = bus.render_idx;
        obs_data[k_iss] = bus.render_data;
        obs_spr[k_iss]  = bus.is_sprite;
        obs_hf[k_iss]   = bus.hflip;
        obs_pal[k_iss]  = bus.palette;
        obs_pri[k_iss]  = bus.render_priority;
        check_val("issue_cycle", 32'(cyc - line_l), 32'(5 + 8 * k_iss));
        check_val("issue_idx", 32'(bus.render_idx), 32'(exp_idx[k_iss]));
        check_val("issue_data", bus.render_data, exp_data[k_iss]);
        check_val("issue_flags",
                  32'({bus.is_sprite, bus.hflip, bus.palette, bus.render_priority}),
                  32'({exp_spr[k_iss], exp_hf[k_iss], exp_pal[k_iss], exp_pri[k_iss]}));
        check_val("busy_during", 32'(busy), 32'd1);
        k_iss++;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check_val("done_cycle", 32'(cyc - line_l), 32'(262 + 8 * (exp_n - 32)));
      check_val("done_items", 32'(k_iss), 32'(exp_n));
      line_act  = 0;
      done_seen = 1;
      done_cyc  = cyc;
    end else if (cyc == done_cyc + 1) begin
      check_val("busy_drop", 32'(busy), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic start_line();
    line_start = 1'b1;
    line_l     = cyc;
    build_expect();
    k_iss      = 0;
    line_act   = 1;
    done_seen  = 0;
    pair_seen  = 0;
    step();
    line_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    check_val("done_seen", 32'(done_seen), 32'd1);
    line_act = 0;
    repeat (3) step();
  endtask

  task automatic rand_tables();
    for (int i = 0; i < 8; i++) begin
      sx_t[i] = 8'($urandom);
      sp_t[i] = 8'($urandom);
      sr_t[i] = 3'($urandom);
    end
  endtask

  int off, d0;

  initial begin
    reset = 1'b1; line_start = 1'b0;
    bg_row = '0; hscroll = '0; nt_base = '0; spr_pattern_base = 1'b0; spr_count = '0;
    pair_a = '1; pair_b = '1; prev_addr = '0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    rand_tables();
    repeat (3) step();
    reset = 1'b0;
    step();
    check_val("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
    check_val("rst_render", {bus.render_data}, 32'd0);
    check_val("rst_idx", 32'(bus.render_idx), 32'd0);
    check_val("rst_bits", 32'({bus.render_start, bus.is_sprite, bus.hflip, bus.palette,
                               bus.render_priority, busy, done, spr_sel}), 32'd0);
    repeat (5) step();
    check_val("idle_vram_addr", 32'(bus.vram_addr), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Background addressing
    nt_base = 3'd7; bg_row = 8'h13; hscroll = 8'h00; spr_count = 4'd0;
    mem[13'h1C40] = 16'h0A05;
    start_line();
    run_to_done(400);
    check_val("bg_name_addr", 32'(addr_t[1]), 32'h1C40);
    check_val("bg_word0_addr", 32'(addr_t[2]), 32'h0056);
    check_val("bg_word1_addr", 32'(addr_t[3]), 32'h0057);
    check_val("bg_first_cycle", 32'(obs_cyc[0] - line_l), 32'd5);
    check_val("bg_first_attr", 32'({obs_idx[0], obs_hf[0], obs_pal[0], obs_pri[0]}), 32'({8'd0, 3'b110}));

    // Vflip, priority, planar conversion
    mem[13'h1C40] = 16'h1405; mem[13'h0058] = 16'h0080; mem[13'h0059] = 16'h0100;
    mem[13'h1C41] = 16'h0006; mem[13'h0066] = 16'hFFFF; mem[13'h0067] = 16'hFFFF;
    start_line();
    run_to_done(400);
    check_val("vf_word0_addr", 32'(addr_t[2]), 32'h0058);
    check_val("vf_word1_addr", 32'(addr_t[3]), 32'h0059);
    check_val("vf_priority", 32'(obs_pri[0]), 32'd1);
    check_val("chunky_edge", obs_data[0], 32'h10000008);
    check_val("chunky_all", obs_data[1], 32'hFFFFFFFF);

    // Scroll wrap
    hscroll = 8'h0D;
    start_line();
    run_to_done(400);
    check_val("scroll_count", 32'(k_iss), 32'd32);
    check_val("scroll_idx0", 32'(obs_idx[0]), 32'h0D);
    check_val("scroll_idx1", 32'(obs_idx[1]), 32'h15);
    check_val("scroll_idx31", 32'(obs_idx[31]), 32'h05);
    check_val("scroll_spacing", 32'(obs_cyc[31] - obs_cyc[30]), 32'd8);

    // Sprites
    hscroll = 8'h00; spr_count = 4'd2; spr_pattern_base = 1'b1;
    sx_t[0] = 8'd250; sp_t[0] = 8'h12; sr_t[0] = 3'd5;
    pair_a = 13'h112A; pair_b = 13'h112B;
    start_line();
    run_to_done(500);
    check_val("spr_pair_read", 32'(pair_seen), 32'd1);
    check_val("spr_first_cycle", 32'(obs_cyc[32] - line_l), 32'd261);
    check_val("spr_first_idx", 32'(obs_idx[32]), 32'd250);
    check_val("spr_first_is_spr", 32'(obs_spr[32]), 32'd1);
    check_val("spr_done_cycle", 32'(done_cyc - line_l), 32'd278);
    pair_a = '1; pair_b = '1;

    // Restart at cycle 100 of a line
    spr_count = 4'd1; d0 = done_cnt;
    start_line();
    while (cyc < line_l + 100) step();
    start_line();
    run_to_done(500);
    check_val("restart_name_addr", 32'(addr_t[1]), 32'({nt_base, bg_row[7:3], 5'd0}));
    check_val("restart_first_cycle", 32'(obs_cyc[0] - line_l), 32'd5);
    check_val("restart_one_done", 32'(done_cnt - d0), 32'd1);

    // Randomized lines, one of them restarted mid-line
    for (int n = 0; n < 6; n++) begin
      nt_base = 3'($urandom); bg_row = 8'($urandom); hscroll = 8'($urandom);
      spr_pattern_base = 1'($urandom); spr_count = 4'($urandom_range(0, 15));
      rand_tables();
      d0 = done_cnt;
      start_line();
      if (n == 2) begin
        off = 5 + 8 * $urandom_range(0, 30) + $urandom_range(3, 7);
        while (cyc < line_l + off) step();
        spr_count = 4'($urandom_range(0, 15));
        start_line();
      end
      run_to_done(600);
      check_val("rand_one_done", 32'(done_cnt - d0), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
